rx_in: RTL

- Receive-side input stage of the 802.16 OFDM chain. It undoes the framing done on transmit.
- Per burst (one CYC_I assertion), it sinks and discards the first PRE_LEN samples, which are the preamble.
- It forwards the remaining data samples downstream on a registered Wishbone-style streaming master port.
- It converts each I/Q component from 1.15 to 7.9 format. The block sits between the ADC/sample source and the receiver's CP-removal/FFT stage.

---
 rtl/rx_in_if.sv | 14 +
 rtl/rx_in.sv | 129 ++++++++++++
 2 files changed

// File: rtl/rx_in_if.sv
// rx_in_if: Wishbone-style streaming link (data, cycle, strobe, write
// enable, acknowledge). The block uses one instance for the sample source
// side and one for the downstream side.
interface rx_in_if;
    logic [31:0] dat;
    logic        cyc;
    logic        stb;
    logic        we;
    logic        ack;

    // Sourcing side drives the sample; sinking side returns the acknowledge.
    modport master (output dat, cyc, stb, we, input  ack);
    modport slave  (input  dat, cyc, stb, we, output ack);
endinterface

// File: rtl/rx_in.sv
// rx_in: receive-side input stage. For each burst it drops the first PRE_LEN
// samples (the preamble), then forwards the remaining samples downstream,
// converting each I/Q half from 1.15 to 7.9.
// Optional build macro: RX_IN_ROUND_EN selects round-half-up conversion
// instead of plain truncation.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for a CYC rising edge, nothing accepted
// S_PRE  | accepting and discarding preamble samples, no backpressure
// S_DATA | forwarding converted samples, honouring downstream ACK
module rx_in #(
    parameter int PRE_LEN = 576,
    parameter int CNT_W   = 10
) (
    input  logic    CLK_I,
    input  logic    RST_I,
    rx_in_if.slave  s_if,
    rx_in_if.master m_if,
    output logic    PRE_ERR
);

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA} state_t;

    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_LEN - 1);

    state_t           state_q;
    logic [CNT_W-1:0] pre_cnt_q;
    logic             icyc_q;
    logic [31:0]      dat_q;
    logic             stb_q;
    logic             cyc_q;
    logic             pre_err_q;

    logic             ena;
    logic             out_halt;
    logic             start;
    logic             ack_o;
    logic [31:0]      dat_d;

    // 1.15 -> 7.9: arithmetic shift right by 6, optionally rounded on bit 5.
    // 0x7FFF rounds to 0x0200 at most, so the rounded result never overflows.
    function automatic logic [15:0] conv16(input logic [15:0] x);
        logic [15:0] sh;
        sh = $signed(x) >>> 6;
`ifdef RX_IN_ROUND_EN
        conv16 = sh + {15'd0, x[5]};
`else
        conv16 = sh;
`endif
    endfunction

    assign ena      = s_if.cyc & s_if.stb & s_if.we;
    assign out_halt = stb_q & ~m_if.ack;
    assign start    = s_if.cyc & ~icyc_q;

    // Accept decision and converted sample for the current input.
    always_comb begin
        ack_o = 1'b0;
        dat_d = {conv16(s_if.dat[31:16]), conv16(s_if.dat[15:0])};
        case (state_q)
            S_PRE:   ack_o = ena;
            S_DATA:  ack_o = ena & ~out_halt;
            default: ack_o = 1'b0;
        endcase
    end

    // Burst sequencing with registered downstream outputs.
    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            state_q   <= S_IDLE;
            pre_cnt_q <= '0;
            icyc_q    <= 1'b0;
            dat_q     <= '0;
            stb_q     <= 1'b0;
            cyc_q     <= 1'b0;
            pre_err_q <= 1'b0;
        end else begin
            icyc_q    <= s_if.cyc;
            pre_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_PRE;
                        pre_cnt_q <= '0;
                    end
                end
                S_PRE: begin
                    // Completing the preamble wins over a CYC drop: the
                    // burst then ends cleanly from S_DATA with no error.
                    if (ack_o) begin
                        if (pre_cnt_q == PRE_LAST) begin
                            state_q <= S_DATA;
                        end else begin
                            pre_cnt_q <= pre_cnt_q + 1'b1;
                        end
                    end else if (!s_if.cyc) begin
                        state_q   <= S_IDLE;
                        pre_err_q <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (!s_if.cyc && (!stb_q || m_if.ack)) begin
                        state_q <= S_IDLE;
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                    end else begin
                        cyc_q <= 1'b1;
                        if (ack_o) begin
                            dat_q <= dat_d;
                            stb_q <= 1'b1;
                        end else if (!out_halt) begin
                            stb_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign s_if.ack = ack_o;
    assign m_if.dat = dat_q;
    assign m_if.cyc = cyc_q;
    assign m_if.stb = stb_q;
    assign m_if.we  = stb_q;
    assign PRE_ERR  = pre_err_q;

endmodule
